// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: request/response channel bundle, N requesters wide, one shared response data bus.
// The master side issues requests and takes responses; the slave side grants requests and returns responses.
interface mem_arbiter_rr_if #(
  parameter int N = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N-1:0]        resp_valid;
  logic [N-1:0]        resp_ready;
  logic [DATA_W-1:0]   resp_data;
  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-to-1 memory request arbiter (round-robin or fixed priority) with grant locking
// and an in-order routing FIFO that steers each downstream response back to its requester.
module mem_arbiter_rr #(
  parameter int CNT = 2,
  parameter int QUEUE_DEPTH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE = 0,
  localparam int OW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_rr_if.slave  c,
  mem_arbiter_rr_if.master s,
  output logic [OW-1:0]   outstanding_o,
  output logic            orphan_err_o
);
  localparam int PW = CNT > 1 ? $clog2(CNT) : 1;
  localparam int QW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  logic [PW-1:0] rr_q, lock_g_q, pick, g, head;
  logic [PW-1:0] fifo_q [QUEUE_DEPTH];
  logic [QW-1:0] wp_q, rp_q;
  logic [OW-1:0] cnt_q;
  logic          lock_q, orphan_q, empty, can_push, req_fire, resp_fire;
  assign empty     = cnt_q == '0;
  assign head      = fifo_q[rp_q];
  assign resp_fire = s.resp_valid[0] && s.resp_ready[0];
  assign req_fire  = s.req_valid[0] && s.req_ready[0];
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign can_push  = (int'(cnt_q) < QUEUE_DEPTH) || resp_fire;
  always_comb begin
    pick = '0;
    for (int k = CNT - 1; k >= 0; k--) begin
      if (c.req_valid[MODE != 0 ? k : (int'(rr_q) + k) % CNT])
        pick = PW'(MODE != 0 ? k : (int'(rr_q) + k) % CNT);
    end
  end
  assign g               = lock_q ? lock_g_q : pick;
  assign s.req_valid[0]  = rst_n && (|c.req_valid) && can_push;
  assign s.req_addr      = c.req_addr[int'(g)*ADDR_W +: ADDR_W];
  assign s.resp_ready[0] = !empty && c.resp_ready[head];
  assign c.resp_data     = s.resp_data;
  always_comb begin
    c.req_ready          = '0;
    c.req_ready[g]       = rst_n && s.req_ready[0] && can_push;
    c.resp_valid         = '0;
    c.resp_valid[head]   = !empty && s.resp_valid[0];
  end
  assign outstanding_o = cnt_q;
  assign orphan_err_o  = orphan_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      lock_q   <= 1'b0;
      lock_g_q <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      lock_q   <= s.req_valid[0] && !s.req_ready[0];
      lock_g_q <= g;
      if (req_fire) begin
        fifo_q[wp_q] <= g;
        wp_q         <= wp_q == QW'(QUEUE_DEPTH - 1) ? '0 : wp_q + 1'b1;
        if (MODE == 0) rr_q <= g == PW'(CNT - 1) ? '0 : g + 1'b1;
      end
      if (resp_fire) rp_q <= rp_q == QW'(QUEUE_DEPTH - 1) ? '0 : rp_q + 1'b1;
      cnt_q    <= cnt_q + OW'(req_fire) - OW'(resp_fire);
      orphan_q <= orphan_q || (empty && s.resp_valid[0]);
    end
  end
endmodule
